// File: rtl/fn_logic_pkg.sv
// Shared constants for the bitwise logic pipeline: operation encodings and the op field width.
package fn_logic_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_ANDN = 2'b11
   } op_e;

endpackage

// File: rtl/fn_pipe_stage.sv
// One elastic register stage holding {valid, Y, zero}; loads whenever it is empty or draining.
module fn_pipe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_y,
   input  logic             i_zero,
   input  logic             i_dn_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_y,
   output logic             o_zero
);

   logic             r_valid;
   logic [WIDTH-1:0] r_y;
   logic             r_zero;
   logic             w_load;

   assign w_load = !r_valid || i_dn_ready;

   // Payload only moves with a valid beat so an emptied stage keeps quiet data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_y     <= '0;
         r_zero  <= 1'b0;
      end else if (w_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_y    <= i_y;
            r_zero <= i_zero;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_y     = r_y;
   assign o_zero  = r_zero;

endmodule

// File: rtl/fn_logic_pipe.sv
// Bitwise logic unit (AND/OR/XOR/ANDN) followed by an elastic pipeline of STAGES registers.
module fn_logic_pipe
   import fn_logic_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             zero
);

   logic [WIDTH-1:0] w_result;
   logic [STAGES:0]  w_valid;
   logic [STAGES:0]  w_zero;
   logic [WIDTH-1:0] w_y [0:STAGES];
   logic [STAGES:0]  w_load;

   always_comb begin
      w_result = '0;
      case (op)
         OP_AND:  w_result = a & b;
         OP_OR:   w_result = a | b;
         OP_XOR:  w_result = a ^ b;
         OP_ANDN: w_result = a & ~b;
         default: w_result = '0;
      endcase
   end

   assign w_valid[0] = in_valid;
   assign w_y[0]     = w_result;
   assign w_zero[0]  = (w_result == '0);

   // Stage k can load iff the consumer is taking a beat or some stage from k
   // onward is empty; written unrolled so the ready chain is built from flop
   // outputs only and never loops back through itself.
   for (genvar g = 0; g < STAGES; g++) begin : g_load
      assign w_load[g] = out_ready || !(&w_valid[STAGES:g+1]);
   end
   assign w_load[STAGES] = out_ready;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      fn_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_valid    (w_valid[g]),
         .i_y        (w_y[g]),
         .i_zero     (w_zero[g]),
         .i_dn_ready (w_load[g+1]),
         .o_valid    (w_valid[g+1]),
         .o_y        (w_y[g+1]),
         .o_zero     (w_zero[g+1])
      );
   end

   assign in_ready  = w_load[0];
   assign out_valid = w_valid[STAGES];
   assign Y         = w_y[STAGES];
   assign zero      = w_zero[STAGES];

endmodule
